// File: rtl/cmplx_mac_pipe.sv
// Pipelined complex multiply-accumulate: (A + j*ja) * (B +/- j*jb) summed over ACC_LEN valid samples.
// Sample on edge t -> multiply -> product reg -> re/im combine -> accumulate; out_valid after edge t+4.
module cmplx_mac_pipe #(
  parameter  int W       = 32,
  parameter  int ACC_LEN = 4,
  localparam int OUT_W   = 2*W + 1 + $clog2(ACC_LEN),
  localparam int CW      = $clog2(ACC_LEN) + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic signed [W-1:0]     A,
  input  logic signed [W-1:0]     ja,
  input  logic signed [W-1:0]     B,
  input  logic signed [W-1:0]     jb,
  input  logic                    conj_b,
  input  logic                    acc_clr,
  output logic signed [OUT_W-1:0] REAL,
  output logic signed [OUT_W-1:0] IMAGINARY,
  output logic                    out_valid,
  output logic [CW-1:0]           frame_cnt
);

  // Stage 1: operand capture
  logic signed [W-1:0] a_q, a_d, ja_q, ja_d, b_q, b_d, jb_q, jb_d;
  logic                conj1_q, conj1_d, v1_q, v1_d;
  // Multiplier output register (products are registered twice so the multipliers can
  // map onto internally pipelined DSP blocks)
  logic signed [2*W-1:0] prm_q, prm_d, pim_q, pim_d, pxm_q, pxm_d, pym_q, pym_d;
  logic                  conjm_q, conjm_d, vm_q, vm_d;
  // Stage 2: product register
  logic signed [2*W-1:0] pr_q, pr_d, pi_q, pi_d, px_q, px_d, py_q, py_d;
  logic                  conj2_q, conj2_d, v2_q, v2_d;
  // Stage 3: combined real/imaginary terms
  logic signed [2*W:0]   re3_q, re3_d, im3_q, im3_d;
  logic                  v3_q, v3_d;
  // Stage 4: accumulator and output registers
  logic signed [OUT_W-1:0] acc_re_q, acc_re_d, acc_im_q, acc_im_d;
  logic signed [OUT_W-1:0] real_q, real_d, imag_q, imag_d;
  logic signed [OUT_W-1:0] sum_re, sum_im;
  logic                    out_valid_q, out_valid_d;
  logic [CW-1:0]           frame_cnt_q, frame_cnt_d;
  logic                    last_of_frame;

  always_comb begin
    // NOTE: every _d gets a default first so no path through this block can infer a latch.
    a_d = a_q;  ja_d = ja_q;  b_d = b_q;  jb_d = jb_q;  conj1_d = conj1_q;
    prm_d = prm_q;  pim_d = pim_q;  pxm_d = pxm_q;  pym_d = pym_q;  conjm_d = conjm_q;
    pr_d = pr_q;  pi_d = pi_q;  px_d = px_q;  py_d = py_q;  conj2_d = conj2_q;
    re3_d = re3_q;  im3_d = im3_q;
    acc_re_d = acc_re_q;  acc_im_d = acc_im_q;
    real_d = real_q;  imag_d = imag_q;
    frame_cnt_d = frame_cnt_q;
    out_valid_d = 1'b0;

    // A sample presented alongside acc_clr still enters as the first of the new frame.
    v1_d = in_valid;
    if (in_valid) begin
      a_d = A;  ja_d = ja;  b_d = B;  jb_d = jb;  conj1_d = conj_b;
    end

    vm_d = v1_q & ~acc_clr;
    if (v1_q) begin
      prm_d   = (2*W)'(a_q)  * (2*W)'(b_q);
      pim_d   = (2*W)'(ja_q) * (2*W)'(jb_q);
      pxm_d   = (2*W)'(a_q)  * (2*W)'(jb_q);
      pym_d   = (2*W)'(ja_q) * (2*W)'(b_q);
      conjm_d = conj1_q;
    end

    v2_d = vm_q & ~acc_clr;
    if (vm_q) begin
      pr_d = prm_q;  pi_d = pim_q;  px_d = pxm_q;  py_d = pym_q;  conj2_d = conjm_q;
    end

    v3_d = v2_q & ~acc_clr;
    if (v2_q) begin
      if (conj2_q) begin
        re3_d = (2*W+1)'(pr_q) + (2*W+1)'(pi_q);
        im3_d = (2*W+1)'(py_q) - (2*W+1)'(px_q);
      end else begin
        re3_d = (2*W+1)'(pr_q) - (2*W+1)'(pi_q);
        im3_d = (2*W+1)'(px_q) + (2*W+1)'(py_q);
      end
    end

    sum_re        = acc_re_q + OUT_W'(re3_q);
    sum_im        = acc_im_q + OUT_W'(im3_q);
    last_of_frame = (frame_cnt_q == CW'(ACC_LEN - 1));

    if (acc_clr) begin
      acc_re_d    = '0;
      acc_im_d    = '0;
      frame_cnt_d = '0;
    end else if (v3_q) begin
      if (last_of_frame) begin
        real_d      = sum_re;
        imag_d      = sum_im;
        out_valid_d = 1'b1;
        acc_re_d    = '0;
        acc_im_d    = '0;
        frame_cnt_d = '0;
      end else begin
        acc_re_d    = sum_re;
        acc_im_d    = sum_im;
        frame_cnt_d = frame_cnt_q + CW'(1);
      end
    end
  end

  // NOTE: datapath registers are reset along with the valid bits so every output reads 0 in reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q <= '0;  ja_q <= '0;  b_q <= '0;  jb_q <= '0;  conj1_q <= 1'b0;  v1_q <= 1'b0;
      prm_q <= '0;  pim_q <= '0;  pxm_q <= '0;  pym_q <= '0;  conjm_q <= 1'b0;  vm_q <= 1'b0;
      pr_q <= '0;  pi_q <= '0;  px_q <= '0;  py_q <= '0;  conj2_q <= 1'b0;  v2_q <= 1'b0;
      re3_q <= '0;  im3_q <= '0;  v3_q <= 1'b0;
      acc_re_q <= '0;  acc_im_q <= '0;
      real_q <= '0;  imag_q <= '0;
      out_valid_q <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every stage samples its predecessor's pre-edge value.
      a_q <= a_d;  ja_q <= ja_d;  b_q <= b_d;  jb_q <= jb_d;  conj1_q <= conj1_d;  v1_q <= v1_d;
      prm_q <= prm_d;  pim_q <= pim_d;  pxm_q <= pxm_d;  pym_q <= pym_d;
      conjm_q <= conjm_d;  vm_q <= vm_d;
      pr_q <= pr_d;  pi_q <= pi_d;  px_q <= px_d;  py_q <= py_d;  conj2_q <= conj2_d;  v2_q <= v2_d;
      re3_q <= re3_d;  im3_q <= im3_d;  v3_q <= v3_d;
      acc_re_q <= acc_re_d;  acc_im_q <= acc_im_d;
      real_q <= real_d;  imag_q <= imag_d;
      out_valid_q <= out_valid_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign REAL      = real_q;
  assign IMAGINARY = imag_q;
  assign out_valid = out_valid_q;
  assign frame_cnt = frame_cnt_q;

endmodule
